mux_4a1: RTL and testbench
==========================

# mux_4a1

Four-input, WIDTH-bit selector with an optional registered output stage. It routes one of four data words to the output according to a 2-bit select formed as {Sa1, Sa0}. The block is a leaf datapath primitive used wherever a small one-of-four choice is needed. A registered shadow output and a select-change pulse are provided for pipelined consumers.

## Interface
- WIDTH, default 1: data and output bit width (≥1).
- clk  input  1  clock; all flops rise-edge.
- rst_n  input  1  asynchronous, active-low reset.
- Da00  input  WIDTH  data word, selected when {Sa1,Sa0}=2'b00.
- Da01  input  WIDTH  data word, selected when {Sa1,Sa0}=2'b01.
- Da10  input  WIDTH  data word, selected when {Sa1,Sa0}=2'b10.
- Da11  input  WIDTH  data word, selected when {Sa1,Sa0}=2'b11.
- Sa1  input  1  select MSB.
- Sa0  input  1  select LSB.
- Ya  output  WIDTH  selected data (combinational unless MUX4A1_REG_OUT_EN).
- Ya_q  output  WIDTH  registered copy of the selected data.
- sel_q  output  2  registered {Sa1,Sa0}.
- sel_chg  output  1  one-cycle pulse when the select changes.
- Declared port order: Da00, Da01, Da10, Da11, Sa1, Sa0, Ya, clk, rst_n, Ya_q, sel_q, sel_chg. Positional instantiation of the first seven must work with clk and rst_n left unconnected in the default build.

## Operation
- sel = {Sa1, Sa0}. Sa1 is the MSB.
- sel mapping: 00→Da00, 01→Da01, 10→Da10, 11→Da11.
- Ya = the selected word, full width, with no masking or arithmetic.
- Ya_q ← selected word on each clk rise.
- sel_q ← sel on each clk rise.
- sel_chg ← (sel != sel_q) on each clk rise. It is high for exactly one cycle after any change, including the first change after reset.
- X or Z on a select bit: Ya is all-X in simulation and don't-care in synthesis.

## Timing
- Default build: Ya is purely combinational with zero cycles of latency. It follows any data or select change within the same delta/timestep.
- Ya_q, sel_q and sel_chg each have 1-cycle latency.
- On rst_n low, asynchronously: Ya_q=0, sel_q=2'b00, sel_chg=0.
- Default build: Ya is unaffected by reset.
- Reset release: the first rising edge with rst_n high captures live inputs. sel_chg fires on that edge if sel != 00.
- Simultaneous data and select change: the output reflects the new select's new data, with no intermediate value guaranteed.

## Configuration
- MUX4A1_REG_OUT_EN defined: Ya is driven from the register (Ya = Ya_q). Ya then has 1-cycle latency and resets to 0 asynchronously.
- MUX4A1_REG_OUT_EN undefined (default): Ya is combinational as described above. Ya_q, sel_q and sel_chg remain present and registered in both builds.

## Structure
- Package mux4a1_pkg contains:
  - enum sel_t: SEL_D00=2'b00, SEL_D01=2'b01, SEL_D10=2'b10, SEL_D11=2'b11.
  - localparam SEL_RST=SEL_D00.
- One sub-module, mux4a1_sel_core: the pure combinational 4:1 select with the WIDTH parameter. It is instantiated once by the top.
- The top holds the registers, change detect and output muxing under the macro.

## Test plan
1. Da00=1, Da01=0, Da10=0, Da11=1 with WIDTH=1; Sa1=0, Sa0=0 → Ya=1.
2. Same data; Sa1=1, Sa0=0 → Ya=0 (Da10). Then Sa1=0, Sa0=1 → Ya=0 (Da01). Then Sa1=1, Sa0=1 → Ya=1 (Da11).
3. WIDTH=8, Da00=8'h11, Da01=8'h22, Da10=8'h33, Da11=8'h44; sweep sel 00..11 at 1 step each → Ya=11, 22, 33, 44. Ya_q matches one clk later.
4. Hold sel=10 for 3 cycles, then set 01 → sel_chg high exactly one cycle, sel_q=2'b01 on that cycle, and low thereafter.
5. Assert rst_n low mid-cycle with Ya_q=8'h44 → Ya_q=0, sel_q=00 and sel_chg=0 immediately, without waiting for clk. Release with sel=11 → next edge gives sel_chg=1 and Ya_q=8'h44.
6. Build with MUX4A1_REG_OUT_EN and repeat test 3 → Ya lags the select by exactly one clk and is 0 during reset.

Source files
------------

// File: rtl/mux4a1_pkg.sv
// Shared select encoding for the mux_4a1 one-of-four selector.
package mux4a1_pkg;

    typedef enum logic [1:0] {
        SEL_D00 = 2'b00,
        SEL_D01 = 2'b01,
        SEL_D10 = 2'b10,
        SEL_D11 = 2'b11
    } sel_t;

    localparam sel_t SEL_RST = SEL_D00;

endpackage

// File: rtl/mux4a1_sel_core.sv
// Pure combinational 4:1 word select; an unknown select yields an all-X word.
module mux4a1_sel_core
    import mux4a1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] d00,
    input  logic [WIDTH-1:0] d01,
    input  logic [WIDTH-1:0] d10,
    input  logic [WIDTH-1:0] d11,
    input  sel_t             sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = 'x;
        case (sel)
            SEL_D00: y = d00;
            SEL_D01: y = d01;
            SEL_D10: y = d10;
            SEL_D11: y = d11;
            // X/Z on a select bit falls through: X in simulation, don't-care in synthesis
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/mux_4a1.sv
// Four-input WIDTH-bit selector with registered shadow output and select-change pulse.
// Define MUX4A1_REG_OUT_EN to drive Ya from the register instead of the combinational path.
module mux_4a1
    import mux4a1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] Da00,
    input  logic [WIDTH-1:0] Da01,
    input  logic [WIDTH-1:0] Da10,
    input  logic [WIDTH-1:0] Da11,
    input  logic             Sa1,
    input  logic             Sa0,
    output logic [WIDTH-1:0] Ya,
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] Ya_q,
    output logic [1:0]       sel_q,
    output logic             sel_chg
);

    logic [1:0]       sel;
    logic [WIDTH-1:0] y_sel;

    assign sel = {Sa1, Sa0};

    mux4a1_sel_core #(
        .WIDTH (WIDTH)
    ) u_sel_core (
        .d00 (Da00),
        .d01 (Da01),
        .d10 (Da10),
        .d11 (Da11),
        .sel (sel_t'(sel)),
        .y   (y_sel)
    );

    // sel_q starts at SEL_RST, so the first non-00 select after reset also pulses sel_chg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Ya_q    <= '0;
            sel_q   <= SEL_RST;
            sel_chg <= 1'b0;
        end else begin
            Ya_q    <= y_sel;
            sel_q   <= sel;
            sel_chg <= (sel != sel_q);
        end
    end

`ifdef MUX4A1_REG_OUT_EN
    assign Ya = Ya_q;
`else
    assign Ya = y_sel;
`endif

endmodule

// File: tb/tb_mux_4a1.sv
// Directed bench for mux_4a1: 8-bit and 1-bit instances, both builds of MUX4A1_REG_OUT_EN.
module tb_mux_4a1;

`ifdef MUX4A1_REG_OUT_EN
    localparam bit REG_BUILD = 1'b1;
`else
    localparam bit REG_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       Sa1, Sa0;
    logic [7:0] Da00, Da01, Da10, Da11;
    logic [7:0] Ya, Ya_q;
    logic [1:0] sel_q;
    logic       sel_chg;

    logic       n00, n01, n10, n11;
    logic       nya, nya_q, nsel_chg;
    logic [1:0] nsel_q;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mux_4a1 #(.WIDTH(8)) dut (
        .Da00(Da00), .Da01(Da01), .Da10(Da10), .Da11(Da11),
        .Sa1(Sa1), .Sa0(Sa0), .Ya(Ya), .clk(clk), .rst_n(rst_n),
        .Ya_q(Ya_q), .sel_q(sel_q), .sel_chg(sel_chg)
    );

    mux_4a1 #(.WIDTH(1)) dut_n (
        .Da00(n00), .Da01(n01), .Da10(n10), .Da11(n11),
        .Sa1(Sa1), .Sa0(Sa0), .Ya(nya), .clk(clk), .rst_n(rst_n),
        .Ya_q(nya_q), .sel_q(nsel_q), .sel_chg(nsel_chg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] words [4];
        logic       nbits [4];
        logic [7:0] prev_w;
        logic       prev_n;
        logic [1:0] prev_s;

        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        nbits = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        {Sa1, Sa0} = 2'b00;
        Da00 = words[0]; Da01 = words[1]; Da10 = words[2]; Da11 = words[3];
        n00 = nbits[0]; n01 = nbits[1]; n10 = nbits[2]; n11 = nbits[3];
        #1;
        chk("rst_ya_q", Ya_q, 8'h00);
        chk("rst_sel_q", sel_q, 2'b00);
        chk("rst_sel_chg", sel_chg, 1'b0);
        chk("rst_ya", Ya, REG_BUILD ? 8'h00 : 8'h11);
        chk("rst_nya", nya, REG_BUILD ? 1'b0 : 1'b1);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_ya_q", Ya_q, 8'h11);
        chk("rel_sel_chg", sel_chg, 1'b0);

        // Sweep 00,10,01,11 on both widths; Ya_q and sel_chg one clock later
        prev_w = 8'h11; prev_n = 1'b1; prev_s = 2'b00;
        foreach (words[k]) begin
            logic [1:0] s;
            s = (k == 1) ? 2'b10 : (k == 2) ? 2'b01 : 2'(k);
            @(negedge clk);
            {Sa1, Sa0} = s;
            #1;
            chk($sformatf("comb_ya_%0d", s), Ya, REG_BUILD ? prev_w : words[s]);
            chk($sformatf("comb_nya_%0d", s), nya, REG_BUILD ? prev_n : nbits[s]);
            @(posedge clk); #1;
            chk($sformatf("reg_ya_q_%0d", s), Ya_q, words[s]);
            chk($sformatf("reg_ya_%0d", s), Ya, words[s]);
            chk($sformatf("reg_sel_q_%0d", s), sel_q, s);
            chk($sformatf("reg_chg_%0d", s), sel_chg, s != prev_s);
            chk($sformatf("reg_nya_q_%0d", s), nya_q, nbits[s]);
            prev_w = words[s]; prev_n = nbits[s]; prev_s = s;
        end

        // Hold 10 for three cycles, then 01
        @(negedge clk);
        {Sa1, Sa0} = 2'b10;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("hold10_chg_%0d", c), sel_chg, c == 0);
            chk($sformatf("hold10_sel_q_%0d", c), sel_q, 2'b10);
        end
        @(negedge clk);
        {Sa1, Sa0} = 2'b01;
        @(posedge clk); #1;
        chk("to01_chg", sel_chg, 1'b1);
        chk("to01_sel_q", sel_q, 2'b01);
        @(posedge clk); #1;
        chk("after01_chg", sel_chg, 1'b0);

        // Simultaneous data and select change
        @(negedge clk);
        {Sa1, Sa0} = 2'b00;
        Da00 = 8'hA5;
        #1;
        chk("simul_ya", Ya, REG_BUILD ? 8'h22 : 8'hA5);
        @(posedge clk); #1;
        chk("simul_ya_q", Ya_q, 8'hA5);
        chk("simul_chg", sel_chg, 1'b1);

        // Async reset mid-cycle while Ya_q holds 8'h44
        @(negedge clk);
        {Sa1, Sa0} = 2'b11;
        @(posedge clk); #1;
        chk("pre_rst_ya_q", Ya_q, 8'h44);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ya_q", Ya_q, 8'h00);
        chk("async_sel_q", sel_q, 2'b00);
        chk("async_chg", sel_chg, 1'b0);
        chk("async_ya", Ya, REG_BUILD ? 8'h00 : 8'h44);
        chk("async_nya_q", nya_q, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel11_chg", sel_chg, 1'b1);
        chk("rel11_ya_q", Ya_q, 8'h44);
        chk("rel11_sel_q", sel_q, 2'b11);
        chk("rel11_nchg", nsel_chg, 1'b1);
        @(posedge clk); #1;
        chk("rel11_chg_low", sel_chg, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
